// File: rtl/spi_response_tx.sv
// spi_response_tx
// MISO-side transmitter of the host SPI link. Response bytes are staged in a
// one-byte holding register (valid/ready). They are shifted out MSB first on
// SPI mode 0, using synchronised copies of the host SCLK and CS_N pins.
// When the host clocks a byte and nothing is staged, IDLE_BYTE is sent and an
// underrun pulse is raised.

module spi_response_tx #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_flush,
  output logic       byte_sent,
  output logic       underrun,
  output logic       tx_abort,
  output logic       busy
);

  // Frame states; S_RELOAD waits for the falling edge that follows the 8th
  // rising edge before the next byte is loaded.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_RELOAD = 2'd2;

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  // Synchroniser chains; the newest sample enters at bit 0.
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csSync;

  // Registered edge strobes taken from the last two chain stages.
  logic r_sclkRise;
  logic r_sclkFall;
  logic r_csFall;
  logic r_csRise;

  // Start-up qualification of chip select. The CS chain resets to 1. If the
  // host already holds CS low when reset releases, the chain shows a false
  // falling edge. The first frame is therefore only accepted after CS has
  // been seen high once the chain holds real pin samples.
  logic [FLUSH_W-1:0] r_flushCnt;
  logic               r_csArmed;

  // Holding register.
  logic [7:0] r_holdData;
  logic       r_holdValid;

  // Shift path and FSM.
  logic [1:0] r_state;
  logic [7:0] r_shreg;
  logic [2:0] r_bitCnt;
  logic       r_miso;
  logic       r_byteSent;
  logic       r_underrun;
  logic       r_txAbort;

  logic       w_sclkRiseRaw;
  logic       w_sclkFallRaw;
  logic       w_csFallRaw;
  logic       w_csRiseRaw;
  logic       w_flushDone;
  logic       w_write;
  logic       w_load;
  logic       w_loadTake;
  logic [7:0] w_loadByte;
  logic [7:0] w_shifted;

  assign w_sclkRiseRaw =  r_sclkSync[SYNC_STAGES-2] & ~r_sclkSync[SYNC_STAGES-1];
  assign w_sclkFallRaw = ~r_sclkSync[SYNC_STAGES-2] &  r_sclkSync[SYNC_STAGES-1];
  assign w_csFallRaw   = ~r_csSync[SYNC_STAGES-2]   &  r_csSync[SYNC_STAGES-1];
  assign w_csRiseRaw   =  r_csSync[SYNC_STAGES-2]   & ~r_csSync[SYNC_STAGES-1];

  assign w_flushDone = (r_flushCnt == FLUSH_W'(SYNC_STAGES));

  // A load happens when a frame opens, or on the falling edge after a
  // completed byte. A same-cycle CS rise always wins.
  assign w_load = !r_csRise &&
                  (((r_state == S_IDLE)   && r_csFall && r_csArmed) ||
                   ((r_state == S_RELOAD) && r_sclkFall));
  assign w_loadTake = w_load && r_holdValid;
  assign w_loadByte = r_holdValid ? r_holdData : IDLE_BYTE;
  assign w_shifted  = r_shreg << 1;

  assign w_write  = tx_valid && !r_holdValid;
  assign tx_ready = !r_holdValid;

  assign spi_miso  = r_miso;
  assign miso_oe   = (r_state != S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign byte_sent = r_byteSent;
  assign underrun  = r_underrun;
  assign tx_abort  = r_txAbort;

  // Bring the asynchronous SPI pins into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclkSync <= '0;
      r_csSync   <= '1;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], spi_cs_n};
    end
  end

  // Register the edge strobes so that each pin edge acts exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclkRise <= 1'b0;
      r_sclkFall <= 1'b0;
      r_csFall   <= 1'b0;
      r_csRise   <= 1'b0;
    end else begin
      r_sclkRise <= w_sclkRiseRaw;
      r_sclkFall <= w_sclkFallRaw;
      r_csFall   <= w_csFallRaw;
      r_csRise   <= w_csRiseRaw;
    end
  end

  // Arm frame starts once the chain is flushed and CS has been seen high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flushCnt <= '0;
      r_csArmed  <= 1'b0;
    end else begin
      if (!w_flushDone) begin
        r_flushCnt <= r_flushCnt + FLUSH_W'(1);
      end
      if (w_flushDone && r_csSync[SYNC_STAGES-1]) begin
        r_csArmed <= 1'b1;
      end
    end
  end

  // Holding register: flush beats a write; a load from hold empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_holdData  <= 8'h00;
      r_holdValid <= 1'b0;
    end else if (tx_flush) begin
      r_holdValid <= 1'b0;
    end else if (w_write) begin
      r_holdData  <= tx_data;
      r_holdValid <= 1'b1;
    end else if (w_loadTake) begin
      r_holdValid <= 1'b0;
    end
  end

  // Frame FSM, shift register, bit counter and the status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shreg    <= 8'h00;
      r_bitCnt   <= 3'd0;
      r_miso     <= 1'b0;
      r_byteSent <= 1'b0;
      r_underrun <= 1'b0;
      r_txAbort  <= 1'b0;
    end else begin
      r_byteSent <= 1'b0;
      r_underrun <= 1'b0;
      r_txAbort  <= 1'b0;
      if (r_csRise) begin
        if ((r_state == S_SHIFT) && (r_bitCnt != 3'd0)) begin
          r_txAbort <= 1'b1;
        end
        r_state  <= S_IDLE;
        r_bitCnt <= 3'd0;
        r_miso   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_bitCnt <= 3'd0;
            r_miso   <= 1'b0;
            if (w_load) begin
              r_shreg    <= w_loadByte;
              r_miso     <= w_loadByte[7];
              r_underrun <= !r_holdValid;
              r_state    <= S_SHIFT;
            end
          end
          S_SHIFT: begin
            if (r_sclkRise) begin
              r_bitCnt <= r_bitCnt + 3'd1;
              if (r_bitCnt == 3'd7) begin
                r_byteSent <= 1'b1;
                r_state    <= S_RELOAD;
              end
            end else if (r_sclkFall) begin
              r_shreg <= w_shifted;
              r_miso  <= w_shifted[7];
            end
          end
          S_RELOAD: begin
            if (w_load) begin
              r_shreg    <= w_loadByte;
              r_miso     <= w_loadByte[7];
              r_underrun <= !r_holdValid;
              r_state    <= S_SHIFT;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_bitCnt <= 3'd0;
            r_miso   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_response_tx.sv
// Self-checking bench for spi_response_tx: acts as a mode-0 SPI host with
// SCLK at clk/16. Expected response bytes go into a scoreboard queue when they
// are staged, and are compared as the host receives them.

module tb_spi_response_tx;

  logic       clk;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_flush;
  logic       byte_sent;
  logic       underrun;
  logic       tx_abort;
  logic       busy;

  int nCompared   = 0;
  int nMismatched = 0;
  int nByteSent   = 0;
  int nUnderrun   = 0;
  int nAbort      = 0;
  int nOeCycles   = 0;

  logic [7:0] expQ[$];

  spi_response_tx #(.IDLE_BYTE(8'hFF), .SYNC_STAGES(3)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush),
    .byte_sent(byte_sent), .underrun(underrun), .tx_abort(tx_abort),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and enable monitors, sampled away from the active edge.
  always @(negedge clk) begin
    if (byte_sent === 1'b1) nByteSent++;
    if (underrun === 1'b1) nUnderrun++;
    if (tx_abort === 1'b1) nAbort++;
    if (miso_oe === 1'b1) nOeCycles++;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Stage one byte in the holding register; waits a bounded time for ready.
  task automatic writeByte(input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    nCompared++;
    if (waited >= 500) begin
      nMismatched++;
      $display("[TB] FAIL write_timeout: tx_ready=%b required 1", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Host clocking: 8 clk high / 8 clk low per bit, samples MISO on the rise.
  // With endFrame, the final falling edge and the CS rise are driven together.
  task automatic clockBits(input int nBits, input bit endFrame, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      spi_sclk = 1'b1;
      rx = {rx[14:0], spi_miso};
      repeat (8) @(negedge clk);
      spi_sclk = 1'b0;
      if (i == nBits - 1 && endFrame) spi_cs_n = 1'b1;
      else repeat (7) @(negedge clk);
    end
  endtask

  task automatic openFrame();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; tx_flush = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({spi_miso, miso_oe, tx_ready, byte_sent, underrun, tx_abort, busy} !== 7'b0010000) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs: got %b required 0010000",
               {spi_miso, miso_oe, tx_ready, byte_sent, underrun, tx_abort, busy});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [15:0] rx;
    logic [7:0]  exp;
    int bs0 = nByteSent, ur0 = nUnderrun, ab0 = nAbort;
    writeByte(8'hA5);
    expQ.push_back(8'hA5);
    nCompared++;
    if (tx_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ready_after_write: got %b required 0", tx_ready);
    end
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    nCompared++;
    if ({miso_oe, tx_ready} !== 2'b00) begin
      nMismatched++;
      $display("[TB] FAIL cs_latency_early: oe/ready=%b required 00", {miso_oe, tx_ready});
    end
    @(negedge clk);
    nCompared++;
    if ({miso_oe, spi_miso, tx_ready, busy} !== 4'b1111) begin
      nMismatched++;
      $display("[TB] FAIL cs_latency_load: oe/miso/ready/busy=%b required 1111",
               {miso_oe, spi_miso, tx_ready, busy});
    end
    repeat (4) @(negedge clk);
    clockBits(8, 1'b1, rx);
    repeat (3) @(negedge clk);
    nCompared++;
    if (miso_oe !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL oe_hold_after_cs_rise: got %b required 1", miso_oe);
    end
    @(negedge clk);
    nCompared++;
    if (miso_oe !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL oe_drop_after_cs_rise: got %b required 0", miso_oe);
    end
    exp = expQ.pop_front();
    nCompared++;
    if (rx[7:0] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL single_byte_data: got %h required %h", rx[7:0], exp);
    end
    repeat (6) @(negedge clk);
    nCompared++;
    if ({nByteSent - bs0, nUnderrun - ur0, nAbort - ab0} !== {32'd1, 32'd0, 32'd0}) begin
      nMismatched++;
      $display("[TB] FAIL single_byte_pulses: sent/underrun/abort=%0d/%0d/%0d required 1/0/0",
               nByteSent - bs0, nUnderrun - ur0, nAbort - ab0);
    end
  endtask

  task automatic test_underrun();
    logic [15:0] rx;
    logic [7:0]  exp;
    int bs0 = nByteSent, ur0 = nUnderrun, ab0 = nAbort;
    expQ.push_back(8'hFF);
    openFrame();
    clockBits(8, 1'b1, rx);
    repeat (10) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if (rx[7:0] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL underrun_data: got %h required %h", rx[7:0], exp);
    end
    nCompared++;
    if ({nByteSent - bs0, nUnderrun - ur0, nAbort - ab0} !== {32'd1, 32'd1, 32'd0}) begin
      nMismatched++;
      $display("[TB] FAIL underrun_pulses: sent/underrun/abort=%0d/%0d/%0d required 1/1/0",
               nByteSent - bs0, nUnderrun - ur0, nAbort - ab0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rx;
    logic [7:0]  exp;
    int bs0 = nByteSent, ur0 = nUnderrun;
    writeByte(8'h3C);
    expQ.push_back(8'h3C);
    openFrame();
    fork
      clockBits(16, 1'b1, rx);
      begin
        repeat (20) @(negedge clk);
        writeByte(8'hC3);
        expQ.push_back(8'hC3);
        repeat (10) @(negedge clk);
        nCompared++;
        if (tx_ready !== 1'b0) begin
          nMismatched++;
          $display("[TB] FAIL ready_while_held: got %b required 0", tx_ready);
        end
      end
    join
    repeat (10) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if (rx[15:8] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_first: got %h required %h", rx[15:8], exp);
    end
    exp = expQ.pop_front();
    nCompared++;
    if (rx[7:0] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_second: got %h required %h", rx[7:0], exp);
    end
    nCompared++;
    if ({nByteSent - bs0, nUnderrun - ur0} !== {32'd2, 32'd0}) begin
      nMismatched++;
      $display("[TB] FAIL b2b_pulses: sent/underrun=%0d/%0d required 2/0",
               nByteSent - bs0, nUnderrun - ur0);
    end
  endtask

  task automatic test_abort();
    logic [15:0] rx;
    logic [7:0]  exp;
    int bs0 = nByteSent, ab0 = nAbort;
    writeByte(8'h81);
    expQ.push_back(8'h81);
    openFrame();
    clockBits(4, 1'b1, rx);
    repeat (3) @(negedge clk);
    nCompared++;
    if (miso_oe !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL abort_oe_hold: got %b required 1", miso_oe);
    end
    @(negedge clk);
    nCompared++;
    if (miso_oe !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL abort_oe_drop: got %b required 0", miso_oe);
    end
    repeat (6) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if (rx[3:0] !== exp[7:4]) begin
      nMismatched++;
      $display("[TB] FAIL abort_partial_bits: got %b required %b", rx[3:0], exp[7:4]);
    end
    nCompared++;
    if ({nByteSent - bs0, nAbort - ab0} !== {32'd0, 32'd1}) begin
      nMismatched++;
      $display("[TB] FAIL abort_pulses: sent/abort=%0d/%0d required 0/1",
               nByteSent - bs0, nAbort - ab0);
    end
    expQ.push_back(8'hFF);
    openFrame();
    clockBits(8, 1'b1, rx);
    repeat (10) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if (rx[7:0] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL abort_next_frame: got %h required %h", rx[7:0], exp);
    end
  endtask

  task automatic test_flush();
    logic [15:0] rx;
    logic [7:0]  exp;
    int ur0 = nUnderrun;
    @(negedge clk);
    tx_data = 8'h55; tx_valid = 1'b1;
    @(negedge clk);
    tx_flush = 1'b1;
    @(negedge clk);
    nCompared++;
    if (tx_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL flush_ready: got %b required 1", tx_ready);
    end
    @(negedge clk);
    nCompared++;
    if (tx_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL flush_beats_write: got %b required 1", tx_ready);
    end
    tx_flush = 1'b0; tx_valid = 1'b0;
    expQ.push_back(8'hFF);
    openFrame();
    clockBits(8, 1'b1, rx);
    repeat (10) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if ({rx[7:0], 32'(nUnderrun - ur0)} !== {exp, 32'd1}) begin
      nMismatched++;
      $display("[TB] FAIL flush_next_frame: got %h underruns %0d required %h / 1",
               rx[7:0], nUnderrun - ur0, exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] rx;
    logic [7:0]  exp;
    int bs0, oe0;
    writeByte(8'h96);
    openFrame();
    clockBits(4, 1'b0, rx);
    @(negedge clk);
    spi_sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nCompared++;
    if ({spi_miso, miso_oe, tx_ready, byte_sent, underrun, tx_abort, busy} !== 7'b0010000) begin
      nMismatched++;
      $display("[TB] FAIL midframe_reset_outputs: got %b required 0010000",
               {spi_miso, miso_oe, tx_ready, byte_sent, underrun, tx_abort, busy});
    end
    spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bs0 = nByteSent;
    oe0 = nOeCycles;
    repeat (10) @(negedge clk);
    clockBits(8, 1'b0, rx);
    repeat (10) @(negedge clk);
    nCompared++;
    if ({nByteSent - bs0, nOeCycles - oe0} !== {32'd0, 32'd0}) begin
      nMismatched++;
      $display("[TB] FAIL no_frame_after_reset: sent/oe_cycles=%0d/%0d required 0/0",
               nByteSent - bs0, nOeCycles - oe0);
    end
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk);
    expQ.push_back(8'hFF);
    openFrame();
    clockBits(8, 1'b1, rx);
    repeat (10) @(negedge clk);
    exp = expQ.pop_front();
    nCompared++;
    if (rx[7:0] !== exp) begin
      nMismatched++;
      $display("[TB] FAIL frame_after_reset: got %h required %h", rx[7:0], exp);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_underrun();
    test_back_to_back();
    test_abort();
    test_flush();
    test_reset_midframe();
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d left required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/spi_response_tx.md
# spi_response_tx

SPI-slave transmit path (MISO side) of the OCR accelerator's host link. It serialises response bytes, such as the status code or the BNN classification result, back to the host over the same SPI bus whose MOSI side is handled by the controller FSM. It runs in the `clk` domain and oversamples the asynchronous SPI pins. It has a one-byte holding register with a valid/ready handshake, and sends a fixed idle byte whenever the host clocks a byte that nothing has loaded.

## Interface
Parameters:
- `IDLE_BYTE`, default 8'hFF: byte shifted out when no data is pending (underrun).
- `SYNC_STAGES`, default 3: synchroniser depth for `spi_sclk` and `spi_cs_n`. Minimum 3, because edge detection compares the last two stages.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `spi_sclk`, input, 1: SPI clock from the host. Asynchronous, mode 0 (CPOL=0, CPHA=0).
- `spi_cs_n`, input, 1: SPI chip select from the host. Asynchronous, active-low.
- `spi_miso`, output, 1: serial data to the host, MSB first. Registered.
- `miso_oe`, output, 1: MISO output enable for the top-level tristate. High only while a frame is active.
- `tx_data`, input, 8: byte to send.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: holding register is empty. A write occurs on a clk edge where `tx_valid && tx_ready`.
- `tx_flush`, input, 1: discard the pending held byte.
- `byte_sent`, output, 1: one-cycle pulse when a full byte has been clocked out.
- `underrun`, output, 1: one-cycle pulse when `IDLE_BYTE` is loaded because the holding register was empty.
- `tx_abort`, output, 1: one-cycle pulse when CS deasserts with 1–7 bits of the current byte shifted.
- `busy`, output, 1: high in any state other than S_IDLE.

## Operation
Synchroniser and edge detection:
- `spi_sclk` and `spi_cs_n` each pass through a `SYNC_STAGES` flop chain.
- Edges are taken from the last two stages: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- The `cs_n` chain resets to 1. The `sclk` chain resets to 0.

Holding register (`hold_data`, `hold_valid`):
- `tx_ready = !hold_valid`.
- A write sets `hold_valid`.
- A shift-register load from hold clears `hold_valid`.
- `tx_flush` clears `hold_valid`, with priority over a same-cycle write. `tx_ready` is high the next cycle.

Shift register (`shreg[7:0]`, `bit_cnt[2:0]`):
- `spi_miso <= shreg[7]` after every load or shift.
- A load takes `hold_data` if `hold_valid`, otherwise `IDLE_BYTE` and pulses `underrun`.

FSM states:
- S_IDLE: `miso_oe=0`, `spi_miso=0`, `bit_cnt=0`. On `cs_fall`, perform a load and go to S_SHIFT.
- S_SHIFT: `miso_oe=1`.
  - On `sclk_rise`, `bit_cnt` increments. When it wraps 7→0, pulse `byte_sent` and go to S_RELOAD.
  - On `sclk_fall`, shift `shreg` left by one, filling 0, and update `spi_miso`.
- S_RELOAD: `miso_oe=1`. On `sclk_fall`, perform a load (next byte) and return to S_SHIFT. Do not shift on this edge.
- Any state, on `cs_rise`: go to S_IDLE, clear `bit_cnt` and drop `miso_oe`.
  - If in S_SHIFT with `bit_cnt != 0`, pulse `tx_abort`. The partially sent byte is discarded, not re-queued.
  - `hold_data`/`hold_valid` are untouched.
- `cs_rise` has priority over an `sclk` edge in the same cycle.

Writes and loads:
- A write in the same cycle as a load when the hold is empty: the load uses `IDLE_BYTE` (pulses `underrun`), and the write lands in hold for the next byte.
- When the hold is full, `tx_ready=0`, so a write and a hold consume never coincide.

## Timing
Reset:
- Outputs: `spi_miso=0`, `miso_oe=0`, `tx_ready=1`, `byte_sent=0`, `underrun=0`, `tx_abort=0`, `busy=0`.
- Internal: `hold_valid=0`, `shreg=0`, state S_IDLE.
- Reset mid-frame returns everything to these values immediately (asynchronous). No pulses are generated.

Latency with `SYNC_STAGES=3` (pin change before clk edge 1):
- The edge is detected after edge 3 and the registered action occurs at edge 4.
- CS falling to first MSB valid on `spi_miso`/`miso_oe`: 4 clk.
- SCLK falling to next bit on `spi_miso`: 4 clk.
- CS rising to `miso_oe` low: 4 clk.

Host requirements:
- SCLK half-period of at least 8 clk. This gives 4 clk of margin before the host samples.
- At least 6 clk from CS falling to the first SCLK rising edge.

Handshakes and pulses:
- `byte_sent` pulses exactly once per 8 rising edges, in the cycle after the 8th detected `sclk_rise`.
- `underrun` and `tx_abort` are single-cycle pulses.

## Test plan
- Write 0xA5, assert CS, 8 SCLK at clk/16 → host samples 1010_0101; one `byte_sent` pulse; `tx_ready` returns to 1 at the load 4 clk after CS falls.
- No write, one 8-bit frame → host reads 0xFF; `underrun` pulses once; no `tx_abort`.
- Write 0x3C, then write 0xC3 while the first byte shifts, 16 SCLK → host reads 0x3C then 0xC3; two `byte_sent` pulses; `tx_ready`=0 while 0xC3 is held; no `underrun`.
- Write 0x81, raise CS after 4 SCLK → `tx_abort` pulse; no `byte_sent`; `miso_oe`=0 4 clk after CS rises; the next frame sends the held byte or 0xFF.
- Write 0x55 then `tx_flush`, with `tx_valid` high in the same cycle as the flush → `tx_ready`=1 next cycle; the next frame reads 0xFF.
- Assert `rst_n` low at bit 5 of a frame → all outputs at reset values in the same cycle; after release with CS still low, there is no `byte_sent` or `miso_oe` until a new CS falling edge.
